// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART. It has a configurable data width,
// parity and stop bits, and a 16x-style oversampled receiver with an input
// synchroniser.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   rx / tx        serial input (asynchronous, idle high) / serial output (idle high)
//   tx_valid, tx_ready, tx_data   host -> transmitter word handshake
//   rx_valid, rx_ready, rx_data   receiver -> host word handshake
//   rx_parity_err, rx_frame_err   per-word flags, qualified by rx_valid
//   rx_overrun     sticky: a frame was dropped while rx_valid was high
//   rx_busy, tx_busy              FSM not in IDLE
//
// Handshake semantics (both directions): a word moves in any cycle where
// valid && ready are both high at the rising clock edge. The producer holds
// valid and data stable until that happens. Ready may depend on internal state
// only, never on valid.
module uart_cfg #(
    parameter int CLK_DIV    = 2604,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy,
    output logic                 tx_busy
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + STOP_BITS + 2);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    // ---------------- oversample tick ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t            tx_state;
    logic                 tx_q;
    logic                 tx_rdy_q;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic [OS_W-1:0]      tx_ticks;
    logic [BIT_W-1:0]     tx_bits;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_ticks == OS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_q     <= 1'b1;
            tx_rdy_q <= 1'b1;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_ticks <= '0;
            tx_bits  <= '0;
        end else begin
            if (tx_state != TX_IDLE && tick)
                tx_ticks <= (tx_ticks == OS_LAST) ? '0 : tx_ticks + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    // tx_rdy_q low in IDLE means a captured word waits for the next tick.
                    if (tx_valid && tx_rdy_q) begin
                        tx_shift <= tx_data;
                        tx_par   <= (PARITY == 2) ? ^tx_data : ~^tx_data;
                        tx_rdy_q <= 1'b0;
                    end else if (!tx_rdy_q && tick) begin
                        tx_state <= TX_START;
                        tx_q     <= 1'b0;
                        tx_ticks <= '0;
                    end
                end
                TX_START: if (tx_bit_end) begin
                    tx_state <= TX_DATA;
                    tx_q     <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bits  <= '0;
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bits == DATA_LAST) begin
                        tx_bits <= '0;
                        if (PARITY != 0) begin
                            tx_state <= TX_PARITY;
                            tx_q     <= tx_par;
                        end else begin
                            tx_state <= TX_STOP;
                            tx_q     <= 1'b1;
                        end
                    end else begin
                        tx_q     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bits  <= tx_bits + 1'b1;
                    end
                end
                TX_PARITY: if (tx_bit_end) begin
                    tx_state <= TX_STOP;
                    tx_q     <= 1'b1;
                end
                TX_STOP: if (tx_bit_end) begin
                    if (tx_bits == STOP_LAST) begin
                        tx_state <= TX_IDLE;
                        tx_rdy_q <= 1'b1;
                    end else begin
                        tx_bits <= tx_bits + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    rx_state_t            rx_state;
    logic                 rx_meta;
    logic                 rxs;
    logic [OS_W-1:0]      rx_ticks;
    logic [BIT_W-1:0]     rx_bits;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_pe_q;
    logic                 rx_fe_q;
    logic                 rx_ov_q;
    logic                 rx_sample;
    logic                 rx_consume;
    logic                 rx_par_exp;
    logic                 rx_par_bad;

    assign rx_sample  = tick && (rx_ticks == OS_LAST);
    assign rx_consume = rx_valid_q && rx_ready;
    assign rx_par_exp = (PARITY == 2) ? ^rx_shift : ~^rx_shift;
    assign rx_par_bad = (PARITY != 0) && (rx_par_bit != rx_par_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_ticks   <= '0;
            rx_bits    <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_pe_q    <= 1'b0;
            rx_fe_q    <= 1'b0;
            rx_ov_q    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            if (rx_consume) begin
                rx_valid_q <= 1'b0;
                rx_pe_q    <= 1'b0;
                rx_fe_q    <= 1'b0;
                rx_ov_q    <= 1'b0;
            end
            if (rx_state != RX_IDLE && rx_state != RX_BREAK && tick)
                rx_ticks <= (rx_ticks == OS_LAST) ? '0 : rx_ticks + 1'b1;
            case (rx_state)
                RX_IDLE: if (tick && !rxs) begin
                    rx_state <= RX_START;
                    rx_ticks <= '0;
                end
                // Mid-start re-check rejects short low glitches silently.
                RX_START: if (tick && rx_ticks == OS_HALF) begin
                    rx_ticks <= '0;
                    rx_bits  <= '0;
                    rx_state <= rxs ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_sample) begin
                    rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                    if (rx_bits == DATA_LAST)
                        rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                    else
                        rx_bits <= rx_bits + 1'b1;
                end
                RX_PARITY: if (rx_sample) begin
                    rx_par_bit <= rxs;
                    rx_state   <= RX_STOP;
                end
                RX_STOP: if (rx_sample) begin
                    // A same-cycle consume frees the holding register first.
                    if (!rx_valid_q || rx_ready) begin
                        rx_data_q  <= rx_shift;
                        rx_valid_q <= 1'b1;
                        rx_pe_q    <= rx_par_bad;
                        rx_fe_q    <= !rxs;
                    end else begin
                        rx_ov_q <= 1'b1;
                    end
                    rx_state <= rxs ? RX_IDLE : RX_BREAK;
                end
                // A held-low line yields one framing-error word, then waits for idle.
                RX_BREAK: if (rxs) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Outputs are forced to their reset values combinationally so a reset
    // takes effect in the cycle it is asserted.
    assign tx            = tx_q | rst;
    assign tx_ready      = tx_rdy_q & ~rst;
    assign tx_busy       = (tx_state != TX_IDLE) & ~rst;
    assign rx_busy       = (rx_state != RX_IDLE) & ~rst;
    assign rx_valid      = rx_valid_q & ~rst;
    assign rx_parity_err = rx_pe_q & ~rst;
    assign rx_frame_err  = rx_fe_q & ~rst;
    assign rx_overrun    = rx_ov_q & ~rst;
    assign rx_data       = rx_data_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Testbench for uart_cfg. It uses three instances:
//   a: 8N1, drives TX and RX directly
//   b: 7 data bits, even parity, 2 stop bits, tx looped back to rx
//   c: 8 data bits, odd parity, 1 stop bit, RX driven from the bench
module tb_uart_cfg;
    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance a
    logic       rx_a, tx_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       pe_a, fe_a, ov_a, rx_busy_a, tx_busy_a;
    // instance b
    logic       tx_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
    logic [6:0] tx_data_b, rx_data_b;
    logic       pe_b, fe_b, ov_b, rx_busy_b, tx_busy_b;
    // instance c
    logic       rx_c, tx_c, tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c;
    logic [7:0] tx_data_c, rx_data_c;
    logic       pe_c, fe_c, ov_c, rx_busy_c, tx_busy_c;

    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
        .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a),
        .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ov_a),
        .rx_busy(rx_busy_a), .tx_busy(tx_busy_a));

    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx(tx_b), .tx(tx_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
        .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
        .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_overrun(ov_b),
        .rx_busy(rx_busy_b), .tx_busy(tx_busy_b));

    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .rx(rx_c), .tx(tx_c),
        .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx_data(tx_data_c),
        .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_data(rx_data_c),
        .rx_parity_err(pe_c), .rx_frame_err(fe_c), .rx_overrun(ov_c),
        .rx_busy(rx_busy_c), .tx_busy(tx_busy_c));

    // scoreboard: {frame_err, parity_err, data[8:0]} or a single expected tx bit
    logic [10:0] exp_q[$];
    logic [10:0] e;
    int checks   = 0;
    int failures = 0;
    int low_cnt, start_cyc, nbit, waited;
    bit started;
    logic [7:0] words_b[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_c = v;
    endtask

    task automatic set_ready(input int which, input logic v);
        if (which == 0)      rx_ready_a = v;
        else if (which == 1) rx_ready_b = v;
        else                 rx_ready_c = v;
    endtask

    function automatic logic rx_vld(input int which);
        if (which == 0)      return rx_valid_a;
        else if (which == 1) return rx_valid_b;
        else                 return rx_valid_c;
    endfunction

    function automatic logic [10:0] rx_obs(input int which);
        if (which == 0)      return {fe_a, pe_a, 1'b0, rx_data_a};
        else if (which == 1) return {fe_b, pe_b, 2'b00, rx_data_b};
        else                 return {fe_c, pe_c, 1'b0, rx_data_c};
    endfunction

    // Serial frame onto rx_a (which=0) or rx_c (which=1).
    task automatic send_serial(input int which, input logic [8:0] data, input int nbits,
                               input bit has_par, input logic par_bit, input int nstop);
        set_rx(which, 1'b0);
        tick_n(BIT_CLK);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            tick_n(BIT_CLK);
        end
        if (has_par) begin
            set_rx(which, par_bit);
            tick_n(BIT_CLK);
        end
        set_rx(which, 1'b1);
        tick_n(BIT_CLK * nstop);
    endtask

    // Bounded wait for rx_valid on instance 'which' (0=a,1=b,2=c).
    task automatic wait_rx(input int which, input string tag);
        int n;
        n = 0;
        while (!rx_vld(which) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rx_vld(which)), 32'd1);
    endtask

    task automatic pop_check(input int which, input string tag);
        logic [10:0] x;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            x = exp_q.pop_front();
            check(tag, 32'(rx_obs(which)), 32'(x));
        end
    endtask

    task automatic consume(input int which);
        set_ready(which, 1'b1);
        @(negedge clk);
        set_ready(which, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rx_c = 1'b1;
        tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
        tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
        rx_ready_a = 1'b0; rx_ready_b = 1'b0; rx_ready_c = 1'b0;
        words_b[0] = 8'h00; words_b[1] = 8'h7F; words_b[2] = 8'h55;

        // ---- reset state ----
        tick_n(3);
        check("reset_outputs", 32'({tx_a, tx_ready_a, rx_valid_a, pe_a, fe_a, ov_a, rx_busy_a, tx_busy_a}),
              32'h80);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(tx_ready_a), 32'd1);

        // ---- 8N1 transmit 0xA5 ----
        exp_q.push_back(11'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(11'((8'hA5 >> i) & 8'h01));
        exp_q.push_back(11'd1);
        tx_data_a  = 8'hA5;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        low_cnt = 0; started = 0; nbit = 0; start_cyc = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (tx_ready_a) break;
            low_cnt++;
            if (!started && !tx_a) begin
                started   = 1;
                start_cyc = cyc;
            end
            if (started && nbit < 10 && ((cyc - start_cyc) % BIT_CLK) == BIT_CLK / 2) begin
                e = exp_q.pop_front();
                check($sformatf("tx1_bit%0d", nbit), 32'(tx_a), 32'(e));
                nbit++;
            end
            if (started && (cyc - start_cyc) == 100)
                check("tx1_busy", 32'(tx_busy_a), 32'd1);
            @(negedge clk);
        end
        check("tx1_bit_count", 32'(nbit), 32'd10);
        check("tx1_ready_back", 32'(tx_ready_a), 32'd1);
        check("tx1_ready_low_window", 32'(low_cnt >= 636 && low_cnt <= 644), 32'd1);

        // ---- glitch on rx ----
        rx_a = 1'b0;
        tick_n(20);
        rx_a = 1'b1;
        tick_n(100);
        check("glitch_idle", 32'({rx_busy_a, rx_valid_a}), 32'd0);

        // ---- rx held low for 20 bit periods ----
        exp_q.push_back({1'b1, 1'b0, 9'h000});
        rx_a = 1'b0;
        tick_n(20 * BIT_CLK);
        rx_a = 1'b1;
        tick_n(200);
        check("break_valid", 32'(rx_valid_a), 32'd1);
        pop_check(0, "break_word");
        check("break_single", 32'(ov_a), 32'd0);
        consume(0);
        check("break_cleared", 32'({rx_valid_a, fe_a}), 32'd0);

        // ---- overrun: two frames without consuming ----
        exp_q.push_back({2'b00, 9'h011});
        send_serial(0, 9'h011, 8, 1'b0, 1'b0, 1);
        send_serial(0, 9'h022, 8, 1'b0, 1'b0, 1);
        tick_n(20);
        check("overrun_flag", 32'({rx_valid_a, ov_a}), 32'd3);
        pop_check(0, "overrun_keeps_first");
        consume(0);
        check("overrun_cleared", 32'({rx_valid_a, ov_a}), 32'd0);

        // ---- odd parity receive, good then inverted parity bit ----
        exp_q.push_back({2'b00, 9'h03C});
        send_serial(1, 9'h03C, 8, 1'b1, 1'b1, 1);
        wait_rx(2, "par_good_valid");
        pop_check(2, "par_good_word");
        consume(2);
        exp_q.push_back({2'b01, 9'h03C});
        send_serial(1, 9'h03C, 8, 1'b1, 1'b0, 1);
        wait_rx(2, "par_bad_valid");
        pop_check(2, "par_bad_word");
        consume(2);

        // ---- loopback 7E2 ----
        for (int w = 0; w < 3; w++) begin
            waited = 0;
            while (!tx_ready_b && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("loop_ready%0d", w), 32'(tx_ready_b), 32'd1);
            exp_q.push_back({2'b00, 2'b00, words_b[w][6:0]});
            tx_data_b  = words_b[w][6:0];
            tx_valid_b = 1'b1;
            @(negedge clk);
            tx_valid_b = 1'b0;
            wait_rx(1, $sformatf("loop_valid%0d", w));
            pop_check(1, $sformatf("loop_word%0d", w));
            consume(1);
        end

        // ---- reset in the middle of a TX data bit ----
        waited = 0;
        while (!tx_ready_a && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        tx_data_a  = 8'h00;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        waited = 0;
        while (tx_a && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tick_n(BIT_CLK + BIT_CLK / 2);
        check("rst6_data_bit_low", 32'(tx_a), 32'd0);
        rst = 1'b1;
        #1;
        check("rst6_same_cycle", 32'({tx_a, tx_ready_a, tx_busy_a}), 32'b100);
        @(negedge clk);
        check("rst6_during", 32'({tx_a, tx_ready_a, tx_busy_a}), 32'b100);
        rst = 1'b0;
        @(negedge clk);
        check("rst6_after", 32'({tx_a, tx_ready_a, tx_busy_a}), 32'b110);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
